// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pkg
// Description : Shared SHA-3 types: variant codes, Keccak state layout, TX FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package sha3_pkg;

   localparam int STATE_BITS = 1600;

   typedef enum logic [1:0] {
      SHA3_224 = 2'd0,
      SHA3_256 = 2'd1,
      SHA3_384 = 2'd2,
      SHA3_512 = 2'd3
   } sha3_variant_t;

   typedef logic [4:0][4:0][63:0] keccak_state_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tx_state_t;

   function automatic int unsigned digest_bits(input sha3_variant_t v);
      int unsigned bits;
      case (v)
         SHA3_224: bits = 224;
         SHA3_256: bits = 256;
         SHA3_384: bits = 384;
         default:  bits = 512;
      endcase
      return bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_state_flatten.sv
`default_nettype none
// ============================================================================
// Module      : keccak_state_flatten
// Description : Maps lane [x][y] of the Keccak state to flat bits 64*(5x+y).
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_state_flatten
   import sha3_pkg::*;
(
   input  keccak_state_t           i_state,
   output logic [STATE_BITS-1:0]   o_flat
);

   for (genvar x = 0; x < 5; x++) begin : g_x
      for (genvar y = 0; y < 5; y++) begin : g_y
         assign o_flat[64*(5*x+y) +: 64] = i_state[x][y];
      end
   end

endmodule
`default_nettype wire

// File: rtl/axis_digest_tx.sv
`default_nettype none
// ============================================================================
// Module      : axis_digest_tx
// Description : Streams the SHA-3 digest of a Keccak state as AXI-Stream words.
//               Optional macro AXIS_DIGEST_TX_BYTESWAP_EN byte-reverses TDATA.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_digest_tx
   import sha3_pkg::*;
#(
   parameter int DATA_WIDTH = 16
)(
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       start,
   input  logic [1:0]                 digest_sel,
   input  logic [4:0][4:0][63:0]      D_in,
   input  logic                       TREADY,
   output logic                       TVALID,
   output logic [DATA_WIDTH-1:0]      TDATA,
   output logic                       TLAST,
   output logic [1:0]                 TID,
   output logic                       busy,
   output logic                       done
);

   localparam int SHREG_BITS = 512;

   logic [STATE_BITS-1:0]   w_flat;
   logic                    w_unused_upper;
   logic [5:0]              w_load_cnt;
   logic                    w_hs;
   logic [DATA_WIDTH-1:0]   w_word;

   tx_state_t               r_state;
   logic [SHREG_BITS-1:0]   r_shreg;
   logic [5:0]              r_cnt;
   logic                    r_tvalid;
   logic                    r_tlast;
   logic [1:0]              r_tid;
   logic                    r_done;

   keccak_state_flatten u_flatten (
      .i_state (D_in),
      .o_flat  (w_flat)
   );

   // Only the low 512 bits can ever be digest bits.
   assign w_unused_upper = ^w_flat[STATE_BITS-1:SHREG_BITS];

   assign w_load_cnt = 6'(digest_bits(sha3_variant_t'(digest_sel)) / DATA_WIDTH - 1);
   assign w_hs       = r_tvalid & TREADY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state  <= ST_IDLE;
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
         r_tid    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_shreg  <= w_flat[SHREG_BITS-1:0];
                  r_tid    <= digest_sel;
                  r_cnt    <= w_load_cnt;
                  r_tvalid <= 1'b1;
                  r_tlast  <= (w_load_cnt == 6'd0);
                  r_state  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_hs) begin
                  if (r_cnt == 6'd0) begin
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_done   <= 1'b1;
                     r_state  <= ST_IDLE;
                  end else begin
                     r_shreg  <= r_shreg >> DATA_WIDTH;
                     r_cnt    <= r_cnt - 6'd1;
                     r_tlast  <= (r_cnt == 6'd1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_word = r_shreg[DATA_WIDTH-1:0];

`ifdef AXIS_DIGEST_TX_BYTESWAP_EN
   for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_swap
      assign TDATA[8*b +: 8] = w_word[DATA_WIDTH-8*(b+1) +: 8];
   end
`else
   assign TDATA = w_word;
`endif

   assign TVALID = r_tvalid;
   assign TLAST  = r_tlast;
   assign TID    = r_tid;
   assign busy   = (r_state == ST_SEND);
   assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_axis_digest_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_digest_tx
// Description : Directed self-checking bench for axis_digest_tx (DATA_WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_digest_tx;

   localparam int DW = 16;
`ifdef AXIS_DIGEST_TX_BYTESWAP_EN
   localparam logic [DW-1:0] FIRST_WORD = 16'hEFCD;
   localparam logic [DW-1:0] DEAD_WORD  = 16'hADDE;
`else
   localparam logic [DW-1:0] FIRST_WORD = 16'hCDEF;
   localparam logic [DW-1:0] DEAD_WORD  = 16'hDEAD;
`endif

   logic                  ACLK = 1'b0;
   logic                  ARESET = 1'b1;
   logic                  start = 1'b0;
   logic [1:0]            digest_sel = 2'd0;
   logic [4:0][4:0][63:0] D_in = '0;
   logic                  TREADY = 1'b0;
   logic                  TVALID;
   logic [DW-1:0]         TDATA;
   logic                  TLAST;
   logic [1:0]            TID;
   logic                  busy;
   logic                  done;

   int vectors = 0;
   int errors  = 0;

   logic [4:0][4:0][63:0] exp_st;
   logic [4:0][4:0][63:0] st_a, st_b, st_c;
   logic [1:0]            exp_id;
   logic [1599:0]         exp_flat;

   axis_digest_tx #(.DATA_WIDTH(DW)) dut (
      .ACLK       (ACLK),
      .ARESET     (ARESET),
      .start      (start),
      .digest_sel (digest_sel),
      .D_in       (D_in),
      .TREADY     (TREADY),
      .TVALID     (TVALID),
      .TDATA      (TDATA),
      .TLAST      (TLAST),
      .TID        (TID),
      .busy       (busy),
      .done       (done)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] exp_word(input int k);
      logic [DW-1:0] w;
      logic [DW-1:0] r;
      w = exp_flat[DW*k +: DW];
      r = w;
`ifdef AXIS_DIGEST_TX_BYTESWAP_EN
      for (int b = 0; b < DW/8; b++) r[8*b +: 8] = w[DW-8*(b+1) +: 8];
`endif
      return r;
   endfunction

   function automatic logic [4:0][4:0][63:0] rand_state();
      logic [4:0][4:0][63:0] s;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            s[x][y] = {$urandom(), $urandom()};
      return s;
   endfunction

   // Called at a falling edge; returns at the falling edge after capture.
   task automatic do_start(input logic [1:0] sel, input logic [4:0][4:0][63:0] st);
      D_in       = st;
      digest_sel = sel;
      start      = 1'b1;
      exp_st     = st;
      exp_id     = sel;
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            exp_flat[64*(5*x+y) +: 64] = st[x][y];
      @(posedge ACLK);
      @(negedge ACLK);
      start = 1'b0;
      D_in  = ~st;
   endtask

   // Receives n words; pat 1 = TREADY 1,0,0,1; mid = cycle of a stray start;
   // stop = word index at which to abandon the transfer (-1 = never).
   task automatic recv(input int n, input int pat, input int mid, input int stop,
                       input int hk, input logic [DW-1:0] hv);
      int   k   = 0;
      int   cyc = 0;
      logic hs;
      while (k < n && k != stop && cyc < 400) begin
         TREADY = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (cyc == mid) begin
            start      = 1'b1;
            digest_sel = 2'd2;
            D_in       = st_c;
         end else begin
            start = 1'b0;
         end
         chk("tvalid", 64'(TVALID), 64'd1);
         chk("tdata",  64'(TDATA),  64'(exp_word(k)));
         chk("tlast",  64'(TLAST),  64'(k == n-1));
         chk("tid",    64'(TID),    64'(exp_id));
         chk("busy",   64'(busy),   64'd1);
         chk("done_in_send", 64'(done), 64'd0);
         if (k == hk) chk("hand_word", 64'(TDATA), 64'(hv));
         hs = TREADY && TVALID;
         @(posedge ACLK);
         @(negedge ACLK);
         if (hs) k++;
         cyc++;
      end
      start = 1'b0;
      if (k == stop) return;
      chk("word_count", 64'(k), 64'(n));
      chk("done_pulse",  64'(done),   64'd1);
      chk("tvalid_idle", 64'(TVALID), 64'd0);
      chk("tlast_idle",  64'(TLAST),  64'd0);
      chk("busy_idle",   64'(busy),   64'd0);
   endtask

   initial begin
      st_a = rand_state();
      st_a[0][0] = 64'h0123_4567_89AB_CDEF;
      st_b = rand_state();
      st_b[0][3] = 64'h0000_0000_DEAD_BEEF;
      st_c = rand_state();

      // Reset state
      repeat (3) @(negedge ACLK);
      chk("rst_tvalid", 64'(TVALID), 64'd0);
      chk("rst_tlast",  64'(TLAST),  64'd0);
      chk("rst_tdata",  64'(TDATA),  64'd0);
      chk("rst_tid",    64'(TID),    64'd0);
      chk("rst_busy",   64'(busy),   64'd0);
      chk("rst_done",   64'(done),   64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("idle_tvalid", 64'(TVALID), 64'd0);

      // SHA3-256, TREADY held high
      do_start(2'd1, st_a);
      recv(16, 0, -1, -1, 0, FIRST_WORD);
      @(negedge ACLK);
      chk("done_one_cycle", 64'(done), 64'd0);

      // SHA3-224, last word from lane [0][3]
      do_start(2'd0, st_b);
      recv(14, 0, -1, -1, 13, DEAD_WORD);
      @(negedge ACLK);

      // SHA3-512 with back-pressure
      do_start(2'd3, st_c);
      recv(32, 1, -1, -1, -1, '0);
      @(negedge ACLK);

      // Stray start during SEND, then start in the done cycle
      do_start(2'd1, st_a);
      recv(16, 0, 5, -1, 0, FIRST_WORD);
      do_start(2'd2, st_c);
      recv(24, 0, -1, -1, -1, '0);
      @(negedge ACLK);
      chk("done_b2b_clear", 64'(done), 64'd0);

      // Reset mid-transfer then replay
      do_start(2'd1, st_a);
      recv(16, 0, -1, 5, -1, '0);
      ARESET = 1'b1;
      #1;
      chk("arst_tvalid", 64'(TVALID), 64'd0);
      chk("arst_busy",   64'(busy),   64'd0);
      chk("arst_tlast",  64'(TLAST),  64'd0);
      @(negedge ACLK);
      chk("arst_done",   64'(done),   64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("post_rst_done", 64'(done), 64'd0);
      do_start(2'd1, st_a);
      recv(16, 0, -1, -1, 0, FIRST_WORD);
      @(negedge ACLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
